// File: rtl/fir_mac_if.sv
// Sample/coefficient/output bundle for the time-multiplexed FIR MAC.
// The FIR is the slave. The testbench or upstream logic is the master.
interface fir_mac_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int TAPS   = 15,
    parameter int OUT_W  = 8
);
    localparam int ADDR_W = $clog2(TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_sat;
    logic [1:0]               state_dbg;

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, out_sat, state_dbg
    );

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, out_sat, state_dbg
    );
endinterface

// File: rtl/fir_mac.sv
// Single-MAC FIR filter. It accepts one sample, runs TAPS multiply-accumulate cycles,
// then emits a rounded and saturated result as a one-cycle out_valid pulse.
module fir_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int TAPS   = 15,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 8
) (
    input  logic      clk,
    input  logic      rst,
    fir_mac_if.slave  bus
);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);

    localparam logic signed [ACC_W:0] OUT_MAX =
        $signed({{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;
    localparam logic signed [ACC_W:0] RND     = $signed({{ACC_W{1'b0}}, 1'b1}) << (SHIFT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_delay [TAPS];
    logic signed [COEF_W-1:0] r_coef  [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [ADDR_W-1:0]        r_idx;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out_data;
    logic                     r_out_sat;

    logic                     w_accept;
    logic                     w_coef_wr;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_rnd;
    logic                     w_hi;
    logic                     w_lo;

    // A sample transfers on a rising edge where in_valid and in_ready are both 1.
    // in_ready is 1 only in IDLE outside reset. in_valid may be held without any other constraint.
    assign bus.in_ready  = rst && (r_state == IDLE);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_coef_wr     = bus.coef_we && rst && (r_state == IDLE) &&
                           ({{(32 - ADDR_W){1'b0}}, bus.coef_addr} < 32'(TAPS));

    assign w_prod        = PROD_W'(r_delay[r_idx]) * PROD_W'(r_coef[r_idx]);
    assign w_prod_ext    = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // The extra MSB keeps the round-half-up addition from wrapping.
    assign w_sum         = $signed({r_acc[ACC_W-1], r_acc}) + RND;
    assign w_rnd         = w_sum >>> SHIFT;
    assign w_hi          = (w_rnd > OUT_MAX);
    assign w_lo          = (w_rnd < OUT_MIN);

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.state_dbg = r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_delay[k] <= '0;
                r_coef[k]  <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (w_coef_wr) begin
                r_coef[bus.coef_addr] <= bus.coef_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_delay[0] <= bus.in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            r_delay[k] <= r_delay[k-1];
                        end
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == ADDR_W'(TAPS - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_out_valid <= 1'b1;
                    if (w_hi) begin
                        r_out_data <= OUT_MAX[OUT_W-1:0];
                        r_out_sat  <= 1'b1;
                    end else if (w_lo) begin
                        r_out_data <= OUT_MIN[OUT_W-1:0];
                        r_out_sat  <= 1'b1;
                    end else begin
                        r_out_data <= w_rnd[OUT_W-1:0];
                        r_out_sat  <= 1'b0;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac.sv
// Directed bench for fir_mac. Instance A (SHIFT=1, OUT_W=16) carries the impulse test.
// Instance B (defaults) carries all other checks. Both instances see the same stimulus.
module tb_fir_mac;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic               t_in_valid  = 1'b0;
    logic signed [7:0]  t_in_data   = '0;
    logic               t_coef_we   = 1'b0;
    logic [3:0]         t_coef_addr = '0;
    logic signed [15:0] t_coef_data = '0;

    fir_mac_if #(.OUT_W(16)) bus_a();
    fir_mac_if               bus_b();

    assign bus_a.in_valid  = t_in_valid;
    assign bus_a.in_data   = t_in_data;
    assign bus_a.coef_we   = t_coef_we;
    assign bus_a.coef_addr = t_coef_addr;
    assign bus_a.coef_data = t_coef_data;
    assign bus_b.in_valid  = t_in_valid;
    assign bus_b.in_data   = t_in_data;
    assign bus_b.coef_we   = t_coef_we;
    assign bus_b.coef_addr = t_coef_addr;
    assign bus_b.coef_data = t_coef_data;

    fir_mac #(.OUT_W(16), .SHIFT(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    fir_mac                          u_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_checks = 0;
    int n_errors = 0;
    logic signed [15:0] exp_q[$];

    typedef struct {
        int coef;
        int x;
        int exp_data;
        int exp_sat;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every driver task is entered just after a negedge and returns just after a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        t_in_valid = 1'b0;
        t_coef_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic write_coef(input int addr, input int data);
        t_coef_we = 1'b1;
        t_coef_addr = 4'(addr);
        t_coef_data = 16'(data);
        @(negedge clk);
        t_coef_we = 1'b0;
    endtask

    task automatic send(input int x, input bit with_wr, input int wr_addr, input int wr_data,
                        input bit mid_wr, input int mid_addr, input int mid_data,
                        output int a_data, output int a_sat, output int b_data,
                        output int b_sat, output int lat);
        bit got;
        got = 1'b0;
        a_data = 0; a_sat = 0; b_data = 0; b_sat = 0;
        t_in_valid = 1'b1;
        t_in_data = 8'(x);
        if (with_wr) begin
            t_coef_we = 1'b1;
            t_coef_addr = 4'(wr_addr);
            t_coef_data = 16'(wr_data);
        end
        @(negedge clk);
        t_in_valid = 1'b0;
        t_coef_we = 1'b0;
        lat = 0;
        if (mid_wr) begin
            t_coef_we = 1'b1;
            t_coef_addr = 4'(mid_addr);
            t_coef_data = 16'(mid_data);
        end
        while (!got && lat < 40) begin
            if (bus_b.out_valid) begin
                got = 1'b1;
                a_data = int'(bus_a.out_data);
                a_sat = int'(bus_a.out_sat);
                b_data = int'(bus_b.out_data);
                b_sat = int'(bus_b.out_sat);
            end else begin
                @(negedge clk);
                t_coef_we = 1'b0;
                lat++;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_valid_timeout: got none expected pulse within 40 cycles");
        end
        @(negedge clk);
        t_coef_we = 1'b0;
        check("out_valid_width", int'(bus_b.out_valid), 0);
    endtask

    initial begin
        int ad, as, bd, bs, lat, seen;

        vecs[0]  = '{32767,  127,  127, 1};
        vecs[1]  = '{32767, -128, -128, 1};
        vecs[2]  = '{  128,    1,    1, 0};
        vecs[3]  = '{  127,    1,    0, 0};
        vecs[4]  = '{  128,   -1,    0, 0};
        vecs[5]  = '{  384,   -1,   -1, 0};
        vecs[6]  = '{  256,  127,  127, 0};
        vecs[7]  = '{  256, -128, -128, 0};
        vecs[8]  = '{  258,  127,  127, 1};
        vecs[9]  = '{ -256, -128,  127, 1};
        vecs[10] = '{  100,   50,   20, 0};
        vecs[11] = '{ -100,   50,  -20, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(bus_b.in_ready), 0);
        check("rst_out_valid", int'(bus_b.out_valid), 0);
        check("rst_out_data", int'(bus_b.out_data), 0);
        check("rst_out_sat", int'(bus_b.out_sat), 0);
        check("rst_state", int'(bus_b.state_dbg), 0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", int'(bus_b.in_ready), 1);
        @(negedge clk);

        // Impulse response on instance A
        for (int k = 0; k < 15; k++) write_coef(k, 2 * (k + 1));
        for (int n = 1; n <= 15; n++) exp_q.push_back(16'(n));
        exp_q.push_back(16'sd0);
        for (int n = 0; n < 16; n++) begin
            send((n == 0) ? 1 : 0, 1'b0, 0, 0, 1'b0, 0, 0, ad, as, bd, bs, lat);
            check("impulse_data", ad, int'(exp_q.pop_front()));
            check("impulse_sat", as, 0);
        end

        // Single-coefficient rounding / saturation table on instance B
        do_reset();
        for (int v = 0; v < 12; v++) begin
            write_coef(0, vecs[v].coef);
            send(vecs[v].x, 1'b0, 0, 0, 1'b0, 0, 0, ad, as, bd, bs, lat);
            check($sformatf("vec%0d_data", v), bd, vecs[v].exp_data);
            check($sformatf("vec%0d_sat", v), bs, vecs[v].exp_sat);
            check($sformatf("vec%0d_latency", v), lat, 16);
        end

        // in_valid held high: accept every 17 cycles, out_valid on the following accept cycle
        t_in_valid = 1'b1;
        for (int i = 0; i < 52; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("hs_ready_c%0d", i), int'(bus_b.in_ready), (i % 17 == 0) ? 1 : 0);
            check($sformatf("hs_valid_c%0d", i), int'(bus_b.out_valid),
                  (i > 0 && i % 17 == 0) ? 1 : 0);
            if (i == 51) t_in_valid = 1'b0;
        end
        @(negedge clk);

        // Reset asserted in the 5th ACCUM cycle
        t_in_valid = 1'b1;
        t_in_data = 8'sd100;
        @(negedge clk);
        t_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_in_rst", int'(bus_b.in_ready), 0);
        check("abort_out_data", int'(bus_b.out_data), 0);
        check("abort_state", int'(bus_b.state_dbg), 0);
        rst = 1'b1;
        #1;
        check("abort_ready_after", int'(bus_b.in_ready), 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_b.out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);
        send(1, 1'b0, 0, 0, 1'b0, 0, 0, ad, as, bd, bs, lat);
        check("abort_coef_clear_a", ad, 0);
        check("abort_coef_clear_b", bd, 0);
        for (int k = 0; k < 15; k++) write_coef(k, 256);
        send(0, 1'b0, 0, 0, 1'b0, 0, 0, ad, as, bd, bs, lat);
        check("abort_taps_clear", bd, 1);

        // Coefficient write gating
        do_reset();
        write_coef(0, 256);
        write_coef(15, 1000);
        send(10, 1'b0, 0, 0, 1'b1, 1, 256, ad, as, bd, bs, lat);
        check("gate_first", bd, 10);
        send(1, 1'b1, 0, 512, 1'b0, 0, 0, ad, as, bd, bs, lat);
        check("gate_impulse", bd, 2);
        check("gate_impulse_sat", bs, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fir_mac.md
FIR_MAC -- requirements
Module: fir_mac

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, the signed input sample width.
REQ-002 The block SHALL provide parameter COEF_W, default 16, the signed coefficient width.
REQ-003 The block SHALL provide parameter TAPS, default 15, the number of filter taps (legal range 2..256).
REQ-004 The block SHALL provide parameter OUT_W, default 8, the signed output width.
REQ-005 The block SHALL provide parameter SHIFT, default 8, the right-shift applied to the accumulator before output (legal range 1..ACC_W-1).
REQ-006 The block SHALL size its accumulator as ACC_W = DATA_W + COEF_W + clog2(TAPS), internal only.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-009 in_valid  input  1  in_data holds a valid sample.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 in_data  input  DATA_W  signed input sample.
REQ-012 coef_we  input  1  coefficient write strobe.
REQ-013 coef_addr  input  clog2(TAPS)  coefficient index.
REQ-014 coef_data  input  COEF_W  signed coefficient value.
REQ-015 out_valid  output  1  one-cycle pulse, out_data is new.
REQ-016 out_data  output  OUT_W  signed filtered sample.
REQ-017 out_sat  output  1  out_data was clipped, valid with out_valid.

Function
REQ-018 The block SHALL be a time-multiplexed single-MAC FIR with FSM states IDLE, ACCUM, DONE.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 On an edge with in_valid=1 and in_ready=1, the block SHALL shift the delay line by one (tap k gets tap k-1), load in_data into tap 0, clear the accumulator, clear the tap index, and go to ACCUM.
REQ-021 In ACCUM, each edge SHALL add delay[idx]*coef[idx] (full-precision signed) to the accumulator and increment idx.
REQ-022 The FSM SHALL leave ACCUM for DONE on the edge performing the idx=TAPS-1 MAC, giving exactly TAPS ACCUM cycles.
REQ-023 On the DONE edge, the block SHALL register out_data = sat(round(acc)), set out_valid=1 for exactly one cycle, and return to IDLE.
REQ-024 round(acc) SHALL be (acc + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT (round half up).
REQ-025 sat() SHALL clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set out_sat=1 when clipping occurs, otherwise out_sat=0.
REQ-026 Latency SHALL be TAPS+1 cycles from the accept edge to the edge that raises out_valid; sustained throughput SHALL be one sample per TAPS+2 cycles.
REQ-027 out_data and out_sat SHALL hold their values until the next DONE edge.
REQ-028 A coefficient write SHALL take effect on the edge where coef_we=1, only when in IDLE and coef_addr<TAPS; all other writes SHALL be ignored.
REQ-029 A coefficient write and a sample accept on the same IDLE edge SHALL both occur, and that sample's computation SHALL use the new coefficient.
REQ-030 The accumulator SHALL never overflow for any input and coefficient values.

Reset
REQ-031 While rst=0 on an edge, the block SHALL set state=IDLE, clear all delay-line taps, coefficients, accumulator and idx to 0, and set out_valid=0, out_data=0, out_sat=0.
REQ-032 in_ready SHALL be 0 while rst=0 and SHALL be 1 in the first cycle after release.
REQ-033 A reset during ACCUM or DONE SHALL abort the computation; no out_valid SHALL follow for the aborted sample.

Verification
REQ-034 Impulse: TAPS=15, SHIFT=1, OUT_W=16, coef[k]=2(k+1), send x=1 then 15 zeros -> out_data 1,2,...,15, then 0; out_sat=0 throughout.
REQ-035 Handshake/latency: defaults, in_valid held 1 -> accepts every 17 cycles, out_valid 16 cycles after each accept edge, one cycle wide.
REQ-036 Saturation: defaults, coef[0]=32767, others 0; x=127 -> out_data=127, out_sat=1; x=-128 -> out_data=-128, out_sat=1.
REQ-037 Rounding: defaults, coef[0]=128, x=1 -> out_data=1; coef[0]=127, x=1 -> out_data=0.
REQ-038 Reset mid-ACCUM: rst=0 on the 5th ACCUM cycle -> no out_valid, out_data=0, coefficients and taps 0, in_ready=1 after release.
REQ-039 Coefficient gating: a write during ACCUM, or a write with coef_addr=15 when TAPS=15 -> coefficient memory unchanged, confirmed by a following impulse response.
